// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, phase constants and the per-phase
// line-drive table used by the single-byte I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    ADDR      = 4'd2,
    ADDR_ACK  = 4'd3,
    WRITE     = 4'd4,
    WRITE_ACK = 4'd5,
    READ      = 4'd6,
    READ_NACK = 4'd7,
    STOP      = 4'd8
  } i2c_state_e;

  // Quarter-bit phases: 0 SCL low/update SDA, 1 release SCL,
  // 2 SCL high/sample SDA, 3 pull SCL low.
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // A set bit means "pull the line low"; a clear bit means "release".
  typedef struct packed {
    logic scl_low;
    logic sda_low;
  } line_drive_t;

  // Open-drain drive pattern for a given state/phase. tx_bit is the data
  // bit currently being shifted out (address or write byte).
  function automatic line_drive_t line_drive(input i2c_state_e st,
                                             input logic [1:0] ph,
                                             input logic       tx_bit);
    line_drive_t ld;
    ld.scl_low = (ph == PH_0) || (ph == PH_3);
    ld.sda_low = 1'b0;
    case (st)
      IDLE: begin
        ld.scl_low = 1'b0;
        ld.sda_low = 1'b0;
      end
      START: begin
        // Both high for phases 0-1, SDA falls at phase 2 with SCL high.
        ld.scl_low = (ph == PH_3);
        ld.sda_low = (ph == PH_2) || (ph == PH_3);
      end
      ADDR, WRITE: begin
        ld.sda_low = ~tx_bit;
      end
      ADDR_ACK, WRITE_ACK, READ, READ_NACK: begin
        ld.sda_low = 1'b0;
      end
      STOP: begin
        // SDA low while SCL rises, SDA released at phase 2 with SCL high.
        ld.scl_low = (ph == PH_0);
        ld.sda_low = (ph == PH_0) || (ph == PH_1);
      end
      default: begin
        ld.scl_low = 1'b0;
        ld.sda_low = 1'b0;
      end
    endcase
    return ld;
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// i2c_clk_div: divides the system clock into quarter-bit ticks and keeps
// the 2-bit phase counter that sequences each SCL bit.
module i2c_clk_div
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign tick  = run && (cnt_q == CNT_MAX);
  assign phase = phase_q;

  // Next divider count and phase; phase advances (and wraps) on each tick.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = PH_0;
    end else if (run) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
    end
  end

  // Divider and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= PH_0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master. Accepts one request on a ready/enable
// handshake and runs START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  i2c_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [7:0]  data_sh_q, data_sh_d;
  logic        rw_q, rw_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_low_q, scl_low_d;
  logic        sda_low_q, sda_low_d;
  logic        sda_meta_q, sda_meta_d;
  logic        sda_sync_q, sda_sync_d;

  logic        accept_s;
  logic        run_s;
  logic        tick_s;
  logic [1:0]  phase_s;
  logic        tx_bit_s;
  line_drive_t drive_s;

  assign run_s = (state_q != IDLE);

  i2c_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .run   (run_s),
    .clear (accept_s),
    .tick  (tick_s),
    .phase (phase_s)
  );

  // Open-drain pins: only ever pull low or release.
  assign sda = sda_low_q ? 1'b0 : 1'bz;
  assign scl = scl_low_q ? 1'b0 : 1'bz;

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;

  // Line drive for the current state/phase plus the SDA input synchronizer.
  always_comb begin
    tx_bit_s   = (state_q == WRITE) ? data_sh_q[7] : addr_sh_q[7];
    drive_s    = line_drive(state_q, phase_s, tx_bit_s);
    scl_low_d  = drive_s.scl_low;
    sda_low_d  = drive_s.sda_low;
    sda_meta_d = sda;
    sda_sync_d = sda_meta_q;
  end

  // Transaction sequencing; everything past IDLE advances only on a tick.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    rw_d       = rw_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    accept_s   = 1'b0;
    if (state_q == IDLE) begin
      if (enable && ready_q) begin
        accept_s  = 1'b1;
        addr_sh_d = {addr, rw};
        data_sh_d = data_in;
        rw_d      = rw;
        ready_d   = 1'b0;
        ack_err_d = 1'b0;
        bit_cnt_d = 3'd7;
        state_d   = START;
      end else begin
        ready_d   = 1'b1;
      end
    end else if (tick_s) begin
      case (state_q)
        START: begin
          if (phase_s == PH_3) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd7;
          end else begin
            state_d   = START;
          end
        end
        ADDR: begin
          if (phase_s == PH_3) begin
            addr_sh_d = {addr_sh_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd0) begin
              state_d   = ADDR_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else begin
            state_d = ADDR;
          end
        end
        ADDR_ACK: begin
          if (phase_s == PH_2) begin
            ack_err_d = sda_sync_q;
          end else if (phase_s == PH_3) begin
            bit_cnt_d = 3'd7;
            if (ack_err_q) begin
              state_d = STOP;
            end else if (rw_q == RW_READ) begin
              state_d = READ;
            end else begin
              state_d = WRITE;
            end
          end else begin
            state_d = ADDR_ACK;
          end
        end
        WRITE: begin
          if (phase_s == PH_3) begin
            data_sh_d = {data_sh_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd0) begin
              state_d   = WRITE_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else begin
            state_d = WRITE;
          end
        end
        WRITE_ACK: begin
          if (phase_s == PH_2) begin
            ack_err_d = ack_err_q | sda_sync_q;
          end else if (phase_s == PH_3) begin
            state_d   = STOP;
          end else begin
            state_d   = WRITE_ACK;
          end
        end
        READ: begin
          if (phase_s == PH_2) begin
            data_sh_d = {data_sh_q[6:0], sda_sync_q};
          end else if (phase_s == PH_3) begin
            if (bit_cnt_q == 3'd0) begin
              // The full byte is present after the last phase-2 sample.
              data_out_d = data_sh_q;
              state_d    = READ_NACK;
            end else begin
              bit_cnt_d  = bit_cnt_q - 3'd1;
            end
          end else begin
            state_d = READ;
          end
        end
        READ_NACK: begin
          if (phase_s == PH_3) begin
            state_d = STOP;
          end else begin
            state_d = READ_NACK;
          end
        end
        STOP: begin
          if (phase_s == PH_3) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            done_d    = 1'b1;
            ready_d   = 1'b1;
          end else begin
            state_d   = STOP;
          end
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      addr_sh_q  <= 8'h00;
      data_sh_q  <= 8'h00;
      rw_q       <= RW_WRITE;
      data_out_q <= 8'h00;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_low_q  <= 1'b0;
      sda_low_q  <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      rw_q       <= rw_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      scl_low_q  <= scl_low_d;
      sda_low_q  <= sda_low_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed vector bench for i2c_master with a clock-sampled
// I2C slave model at 0x52 and a START/STOP edge monitor on the bus.
module tb_i2c_master;

  localparam int CLK_DIV   = 4;
  localparam int FULL_CLKS = 80 * CLK_DIV;
  localparam int NACK_CLKS = 44 * CLK_DIV;
  localparam int TIMEOUT   = 4000;
  localparam logic [6:0] SLV_ADDR = 7'h52;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] addr = 7'h00;
  logic       rw = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       ready;
  logic       done;
  logic       ack_err;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  logic s_drive_low = 1'b0;
  assign sda = s_drive_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .addr     (addr),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .done     (done),
    .ack_err  (ack_err),
    .sda      (sda),
    .scl      (scl)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model and bus monitor ----------------
  // Stages: 0 address, 1 address ack, 2 data, 3 data ack, 4 idle.
  logic [7:0] s_rd_byte = 8'hCC;
  int         s_stage = 4;
  int         s_bits = 0;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_addr_byte = 8'h00;
  logic [7:0] s_cap = 8'h00;
  logic       s_match = 1'b0;
  logic       s_read = 1'b0;
  logic       s_mack = 1'b0;
  logic       s_data_seen = 1'b0;
  logic       sda_prev = 1'b1;
  logic       scl_prev = 1'b1;
  int         n_start = 0;
  int         n_stop = 0;

  // Bus-edge driven slave: SDA moving while SCL high is only legal as START/STOP.
  always @(posedge clk) begin
    sda_prev <= sda;
    scl_prev <= scl;
    if (scl_prev && scl && (sda != sda_prev)) begin
      if (!sda) begin
        n_start     <= n_start + 1;
        s_stage     <= 0;
        s_bits      <= 0;
        s_data_seen <= 1'b0;
        s_drive_low <= 1'b0;
      end else begin
        n_stop      <= n_stop + 1;
        s_stage     <= 4;
        s_drive_low <= 1'b0;
      end
    end else if (!scl_prev && scl) begin
      case (s_stage)
        0: begin
          s_sh   <= {s_sh[6:0], sda};
          s_bits <= s_bits + 1;
        end
        2: begin
          if (!s_read) s_sh <= {s_sh[6:0], sda};
          s_bits <= s_bits + 1;
        end
        3: s_mack <= sda;
        default: ;
      endcase
    end else if (scl_prev && !scl) begin
      case (s_stage)
        0: begin
          if (s_bits == 8) begin
            s_addr_byte <= s_sh;
            s_match     <= (s_sh[7:1] == SLV_ADDR);
            s_read      <= s_sh[0];
            s_drive_low <= (s_sh[7:1] == SLV_ADDR);
            s_stage     <= 1;
          end
        end
        1: begin
          s_bits <= 0;
          if (s_match) begin
            s_stage     <= 2;
            s_data_seen <= 1'b1;
            s_drive_low <= s_read ? ~s_rd_byte[7] : 1'b0;
          end else begin
            s_stage     <= 4;
            s_drive_low <= 1'b0;
          end
        end
        2: begin
          if (s_bits == 8) begin
            s_stage <= 3;
            if (s_read) begin
              s_drive_low <= 1'b0;
            end else begin
              s_cap       <= s_sh;
              s_drive_low <= 1'b1;
            end
          end else if (s_read) begin
            s_drive_low <= ~s_rd_byte[7 - s_bits];
          end
        end
        3: begin
          s_drive_low <= 1'b0;
          s_stage     <= 4;
        end
        default: ;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(output int clks);
    clks = 0;
    while (done !== 1'b1 && clks < TIMEOUT) begin
      @(negedge clk);
      clks++;
    end
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] srd;
    logic [7:0] exp_abyte;
    logic       exp_ack_err;
    logic [7:0] exp_dout;
    int         exp_clks;
    logic       exp_data;
  } vec_t;

  vec_t vecs[6];
  int   clks;

  initial begin
    vecs[0] = '{7'h52, 1'b0, 8'h3C, 8'hCC, 8'hA4, 1'b0, 8'h00, FULL_CLKS, 1'b1};
    vecs[1] = '{7'h52, 1'b1, 8'h00, 8'hCC, 8'hA5, 1'b0, 8'hCC, FULL_CLKS, 1'b1};
    vecs[2] = '{7'h11, 1'b0, 8'h55, 8'hCC, 8'h22, 1'b1, 8'hCC, NACK_CLKS, 1'b0};
    vecs[3] = '{7'h52, 1'b0, 8'h81, 8'hCC, 8'hA4, 1'b0, 8'hCC, FULL_CLKS, 1'b1};
    vecs[4] = '{7'h52, 1'b1, 8'h00, 8'h5A, 8'hA5, 1'b0, 8'h5A, FULL_CLKS, 1'b1};
    vecs[5] = '{7'h11, 1'b1, 8'h00, 8'h5A, 8'h23, 1'b1, 8'h5A, NACK_CLKS, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",    ready,    1);
    check("rst_done",     done,     0);
    check("rst_ack_err",  ack_err,  0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_sda",      sda,      1);
    check("rst_scl",      scl,      1);

    // Table-driven transactions.
    for (int i = 0; i < 6; i++) begin
      s_rd_byte = vecs[i].srd;
      wait_ready();
      addr    = vecs[i].addr;
      rw      = vecs[i].rw;
      data_in = vecs[i].wdata;
      enable  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      check($sformatf("v%0d_busy", i), ready, 0);
      wait_done(clks);
      check($sformatf("v%0d_clocks", i),   clks,     vecs[i].exp_clks);
      check($sformatf("v%0d_ack_err", i),  ack_err,  vecs[i].exp_ack_err);
      check($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_dout);
      check($sformatf("v%0d_ready", i),    ready,    1);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_sda_free", i),   sda,  1);
      check($sformatf("v%0d_scl_free", i),   scl,  1);
      check($sformatf("v%0d_bus_addr", i),   s_addr_byte, vecs[i].exp_abyte);
      check($sformatf("v%0d_data_phase", i), s_data_seen, vecs[i].exp_data);
      if (vecs[i].exp_data && !vecs[i].rw)
        check($sformatf("v%0d_slave_cap", i), s_cap, vecs[i].wdata);
      if (vecs[i].exp_data && vecs[i].rw)
        check($sformatf("v%0d_master_nack", i), s_mack, 1);
    end

    // Reset during ADDR bit 3: lines released asynchronously, status cleared.
    wait_ready();
    addr = 7'h52; rw = 1'b0; data_in = 8'hC3; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (81) @(negedge clk);
    check("mid_busy",      ready, 0);
    check("mid_scl_low",   scl,   0);
    rst = 1'b1;
    #1;
    check("mid_rst_sda",      sda,      1);
    check("mid_rst_scl",      scl,      1);
    check("mid_rst_ready",    ready,    1);
    check("mid_rst_data_out", data_out, 8'h00);
    check("mid_rst_ack_err",  ack_err,  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back with enable held: NACK transaction then immediate write.
    addr = 7'h11; rw = 1'b0; data_in = 8'hAA; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_busy", ready, 0);
    wait_done(clks);
    check("b2b_first_clocks",  clks,    NACK_CLKS);
    check("b2b_first_ack_err", ack_err, 1);
    check("b2b_first_ready",   ready,   1);
    addr = 7'h52; data_in = 8'h77;
    @(negedge clk);
    check("b2b_second_taken",   ready,   0);
    check("b2b_ack_err_clear",  ack_err, 0);
    check("b2b_done_low",       done,    0);
    enable = 1'b0;
    wait_done(clks);
    check("b2b_second_clocks",  clks,    FULL_CLKS);
    check("b2b_second_ack_err", ack_err, 0);
    check("b2b_second_cap",     s_cap,   8'h77);
    @(negedge clk);

    // Bus-level edge accounting: 9 STARTs, 8 STOPs (reset aborted one).
    check("bus_starts", n_start, 9);
    check("bus_stops",  n_stop,  8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
